i_type_issue: RTL
=================

Name: i_type_issue

Overview:
- Producer side of the I-type ALU interface.
- Accepts raw instructions through a valid/ready handshake and decodes the I-type fields.
- Reads rs1 from an internal 32x32 register file, sign-extends the immediate, and drives idata/rv1/imm to the combinational I-type ALU.
- Registers the ALU result into a write-back stage and writes rd, with WB-to-ID forwarding and downstream backpressure.

Parameters:
- XLEN, 32, data width; must match MSB-LSB+1 from the parameters package.
- NREGS, 32, register file depth; x0 is hardwired to zero.
- CNTW, 16, width of the illegal-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction word is valid.
- instr_in  in  32  instruction word.
- instr_ready  out  1  issue stage can accept an instruction this cycle.
- alu_idata  out  32  instruction held in the ID stage, to the ALU.
- alu_rv1  out  32  rs1 value, forwarded if required.
- alu_imm  out  32  sign-extended imm[11:0] (instr[31:20]).
- alu_result  in  32  combinational ALU result for alu_idata.
- wb_valid  out  1  write-back entry valid.
- wb_ready  in  1  downstream accepts the write-back entry.
- wb_rd  out  5  destination register.
- wb_data  out  32  result being written.
- retired_count  out  32  count of completed write-backs.
- illegal_count  out  CNTW  count of dropped illegal instructions.
- dbg_raddr  in  5  debug read address.
- dbg_rdata  out  32  register file contents at dbg_raddr (combinational, no forwarding).

Behaviour:
- Reset (synchronous, active-high):
  - id_valid=0, wb_valid=0, wb_rd=0, wb_data=0.
  - Counters =0; all registers =0.
  - alu_idata/alu_rv1/alu_imm =0.
  - instr_ready=1 in the cycle after reset deasserts.
  - Reset mid-operation discards in-flight ID and WB entries with no register write.
- Pipeline: two stages, ID then WB.
  - ID register loads on instr_valid && instr_ready.
  - ALU outputs are driven from ID register contents during the following cycle.
  - WB register captures alu_result, rd and valid at the end of that cycle.
  - Accept in cycle N -> alu_* valid in N+1 -> wb_valid in N+2.
- Flow control:
  - wb_stall = wb_valid && !wb_ready.
  - WB advances when !wb_stall.
  - ID advances into WB when id_valid && !wb_stall.
  - instr_ready = !id_valid || !wb_stall.
  - With wb_ready held at 1, one instruction issues per cycle.
- Legality check, performed in ID; an illegal instruction is dropped, creates no WB entry and increments illegal_count by 1 (saturating):
  - opcode != 7'b0010011.
  - funct3=001 with instr[31:25] != 0.
  - funct3=101 with instr[31:25] not in {0000000, 0100000}.
- alu_imm: {{20{instr[31]}}, instr[31:20]}. It is passed unmodified for shifts; the ALU uses imm[4:0].
- alu_idata is the full instruction word, so the ALU sees the opcode and instr[30].
- alu_rv1 source, in priority order:
  1. 0 if rs1==0.
  2. wb_data if wb_valid && wb_rd==rs1.
  3. Otherwise regfile[rs1].
- Register write:
  - regfile[wb_rd] <= wb_data on wb_valid && wb_ready && wb_rd!=0.
  - Writes to x0 still complete the handshake and count as retired; x0 stays 0.
- retired_count increments by 1 on each wb_valid && wb_ready and wraps at 2^32.
- While stalled, WB holds wb_rd and wb_data stable and ID holds alu_* stable.
- The forward path remains valid while WB is stalled.
- dbg_raddr=0 always returns 0.

Test Plan:
- addi x1,x0,5 (0x00500093) then, in the next cycle, addi x2,x1,-1 (0xFFF08113), wb_ready=1:
  - wb_valid in N+2 with rd=1, data=5.
  - Next cycle wb_valid with rd=2, data=4 (forwarded).
  - dbg x2=4; retired_count=2.
- Hold wb_ready=0 for 3 cycles with 3 instructions offered back-to-back:
  - wb_rd/wb_data stable while wb_ready=0.
  - instr_ready=0 once ID and WB are both full.
  - No instruction lost or duplicated after release; results match in order.
- Drop cases:
  - Issue 0x00000033 (R-type add): no wb_valid, illegal_count=1.
  - Issue slli with instr[31:25]=0000001: illegal_count=2, registers unchanged.
- addi x0,x0,7 (0x00700013):
  - Completes a handshake with wb_rd=0, data=7; retired_count increments.
  - dbg_raddr=0 returns 0; a following addi x3,x0,0 writes x3=0.
- Assert reset for one cycle while ID and WB both hold valid entries:
  - Next cycle wb_valid=0, counters=0, all regs=0, no write of the pending result.
- Boundary values:
  - Load x1=0x7FFFFFFF via addi/slli/ori sequence, then addi x4,x1,1: wb_data=0x80000000.
  - slti x5,x1,-1: wb_data=0.

Source files
------------

// File: rtl/i_type_issue.sv
// I-type issue stage: instruction handshake, ID decode/legality, rs1 read with WB forwarding,
// and a backpressured write-back stage that retires into the internal register file.
module i_type_issue #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned CNTW  = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            instr_valid,
    input  logic [31:0]     instr_in,
    output logic            instr_ready,
    output logic [31:0]     alu_idata,
    output logic [XLEN-1:0] alu_rv1,
    output logic [XLEN-1:0] alu_imm,
    input  logic [XLEN-1:0] alu_result,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic [31:0]     retired_count,
    output logic [CNTW-1:0] illegal_count,
    input  logic [4:0]      dbg_raddr,
    output logic [XLEN-1:0] dbg_rdata
);

    localparam logic [6:0] OpImm = 7'b0010011;

    logic            id_valid_q, id_valid_d;
    logic [31:0]     id_instr_q, id_instr_d;
    logic            wb_valid_q, wb_valid_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic [31:0]     retired_q, retired_d;
    logic [CNTW-1:0] illegal_q, illegal_d;
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1;
    logic [4:0] rd;
    logic       id_legal;
    logic       wb_stall;
    logic       wb_fire;
    logic       id_fire;

    always_comb begin
        opcode   = id_instr_q[6:0];
        funct3   = id_instr_q[14:12];
        funct7   = id_instr_q[31:25];
        rs1      = id_instr_q[19:15];
        rd       = id_instr_q[11:7];
        id_legal = (opcode == OpImm);
        if (funct3 == 3'b001 && funct7 != 7'b0000000) begin
            id_legal = 1'b0;
        end
        if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000) begin
            id_legal = 1'b0;
        end
    end

    always_comb begin
        wb_stall    = wb_valid_q && !wb_ready;
        wb_fire     = wb_valid_q && wb_ready;
        id_fire     = id_valid_q && !wb_stall;
        instr_ready = !id_valid_q || !wb_stall;
    end

    // ALU operands come straight from the ID register; rs1 forwards from the pending WB entry.
    always_comb begin
        alu_idata = id_instr_q;
        alu_imm   = {{(XLEN-12){id_instr_q[31]}}, id_instr_q[31:20]};
        if (rs1 == 5'd0) begin
            alu_rv1 = '0;
        end else if (wb_valid_q && wb_rd_q == rs1) begin
            alu_rv1 = wb_data_q;
        end else begin
            alu_rv1 = regs_q[rs1];
        end
    end

    always_comb begin
        id_valid_d = id_valid_q;
        id_instr_d = id_instr_q;
        if (instr_ready) begin
            id_valid_d = instr_valid;
            if (instr_valid) begin
                id_instr_d = instr_in;
            end
        end

        wb_valid_d = wb_valid_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        if (!wb_stall) begin
            wb_valid_d = id_fire && id_legal;
            if (id_fire && id_legal) begin
                wb_rd_d   = rd;
                wb_data_d = alu_result;
            end
        end

        regs_d = regs_q;
        if (wb_fire && wb_rd_q != 5'd0) begin
            regs_d[wb_rd_q] = wb_data_q;
        end

        retired_d = retired_q + {31'd0, wb_fire};

        illegal_d = illegal_q;
        if (id_fire && !id_legal && illegal_q != {CNTW{1'b1}}) begin
            illegal_d = illegal_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            id_valid_q <= 1'b0;
            id_instr_q <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            retired_q  <= '0;
            illegal_q  <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            id_valid_q <= id_valid_d;
            id_instr_q <= id_instr_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            retired_q  <= retired_d;
            illegal_q  <= illegal_d;
            regs_q     <= regs_d;
        end
    end

    always_comb begin
        wb_valid      = wb_valid_q;
        wb_rd         = wb_rd_q;
        wb_data       = wb_data_q;
        retired_count = retired_q;
        illegal_count = illegal_q;
        dbg_rdata     = (dbg_raddr == 5'd0) ? '0 : regs_q[dbg_raddr];
    end

endmodule
